// File: rtl/ble_phy_pkg.sv
// rtl/ble_phy_pkg.sv - shared types and constants for the BLE PHY transmit CRC path
package ble_phy_pkg;

    localparam int CRC_LEN = 16;

    typedef logic [7:0] pdu_len_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/ble_tx_byte_serializer.sv
// rtl/ble_tx_byte_serializer.sv - payload byte shift/holding registers with bit counter
// Ports:
//   i_load       first byte of a packet is on i_byte_in this cycle
//   i_shift_en   controller is in its shifting state
//   i_more       at least one payload byte has not been loaded yet
//   i_byte_vld / i_byte_in   payload byte delivery
//   o_data_bit / o_valid     registered bit stream towards the CRC block
//   o_need_byte  bit 0 of a byte is on the output
//   o_last_bit   bit 7 of a byte is on the output
//   o_hold_full  next byte is waiting in the holding register
module ble_tx_byte_serializer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_shift_en,
    input  logic       i_more,
    input  logic       i_byte_vld,
    input  logic [7:0] i_byte_in,
    output logic       o_data_bit,
    output logic       o_valid,
    output logic       o_need_byte,
    output logic       o_last_bit,
    output logic       o_hold_full
);

    logic [7:0] r_shreg;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [2:0] r_bit_idx;
    logic       r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_idx   <= '0;
            r_valid     <= 1'b0;
        end else if (i_load) begin
            r_shreg     <= i_byte_in;
            r_bit_idx   <= '0;
            r_valid     <= 1'b1;
            r_hold_full <= 1'b0;
        end else if (i_shift_en && r_valid) begin
            if (r_bit_idx == 3'd7) begin
                // Back-to-back bytes: swap in the held byte so valid never gaps.
                if (i_more && r_hold_full) begin
                    r_shreg   <= r_hold;
                    r_bit_idx <= '0;
                end else begin
                    r_shreg <= '0;
                    r_valid <= 1'b0;
                end
                r_hold_full <= 1'b0;
            end else begin
                r_shreg   <= r_shreg >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
                // A byte arriving on bit 7 is too late to be used and is dropped.
                if (i_byte_vld && !r_hold_full) begin
                    r_hold      <= i_byte_in;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    assign o_data_bit  = r_shreg[0];
    assign o_valid     = r_valid;
    assign o_need_byte = r_valid && (r_bit_idx == 3'd0);
    assign o_last_bit  = r_valid && (r_bit_idx == 3'd7);
    assign o_hold_full = r_hold_full;

endmodule

// File: rtl/ble_tx_crc_sequencer.sv
// rtl/ble_tx_crc_sequencer.sv - sequences payload bytes into the BLE TX CRC block
// Ports:
//   i_start/i_pdu_len/i_seed  packet request (length and seed latched when accepted)
//   o_byte_req/i_byte_in/i_byte_vld  payload buffer handshake
//   o_crc_data_bit/o_crc_valid_in/o_crc_uap_dci/i_crc_flag  CRC block interface
//   o_busy/o_done/o_total_bits/o_err_underrun/o_err_timeout  TX control status
module ble_tx_crc_sequencer
    import ble_phy_pkg::*;
#(
    parameter int MAX_LEN    = 255,
    parameter int CRC_LEN    = ble_phy_pkg::CRC_LEN,
    parameter int GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  pdu_len_t    i_pdu_len,
    input  logic [7:0]  i_seed,
    output logic        o_byte_req,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_vld,
    output logic        o_crc_data_bit,
    output logic        o_crc_valid_in,
    output logic [7:0]  o_crc_uap_dci,
    input  logic        i_crc_flag,
    output logic        o_busy,
    output logic        o_done,
    output logic [13:0] o_total_bits,
    output logic        o_err_underrun,
    output logic        o_err_timeout
);

    localparam int LW       = $clog2(MAX_LEN + 1);
    localparam int TAIL_MAX = CRC_LEN + 4;
    localparam int TW       = $clog2(TAIL_MAX);
    localparam int GW       = $clog2(GAP_CYCLES + 1);

    state_t        r_state, w_next;
    logic [LW-1:0] r_bytes_left;
    logic [7:0]    r_seed;
    logic [13:0]   r_total_bits;
    logic          r_busy, r_done, r_req_first;
    logic          r_err_underrun, r_err_timeout;
    logic          r_flag_seen;
    logic [TW-1:0] r_tail_cnt;
    logic [GW-1:0] r_gap_cnt;

    logic w_accept, w_load_first, w_shift_en, w_more;
    logic w_need_byte, w_last_bit, w_hold_full;
    logic w_reload, w_underrun, w_flag_fall, w_tail_exp, w_gap_end;

    assign w_accept     = (r_state == ST_IDLE) && i_start;
    assign w_load_first = (r_state == ST_FETCH) && i_byte_vld;
    assign w_shift_en   = (r_state == ST_SHIFT);
    assign w_more       = (r_bytes_left != '0);
    assign w_reload     = w_shift_en && w_last_bit && w_more && w_hold_full;
    assign w_underrun   = w_shift_en && w_last_bit && w_more && !w_hold_full;
    assign w_flag_fall  = (r_state == ST_TAIL) && r_flag_seen && !i_crc_flag;
    assign w_tail_exp   = (r_state == ST_TAIL) && (r_tail_cnt == TW'(TAIL_MAX - 1));
    assign w_gap_end    = (r_state == ST_GAP) && (r_gap_cnt == GW'(GAP_CYCLES - 1));

    ble_tx_byte_serializer u_ser (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (w_load_first),
        .i_shift_en  (w_shift_en),
        .i_more      (w_more),
        .i_byte_vld  (i_byte_vld),
        .i_byte_in   (i_byte_in),
        .o_data_bit  (o_crc_data_bit),
        .o_valid     (o_crc_valid_in),
        .o_need_byte (w_need_byte),
        .o_last_bit  (w_last_bit),
        .o_hold_full (w_hold_full)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start && (i_pdu_len != '0)) w_next = ST_FETCH;
            ST_FETCH: if (i_byte_vld) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit && !w_reload) w_next = ST_TAIL;
            ST_TAIL:  if (w_flag_fall || w_tail_exp) w_next = ST_GAP;
            ST_GAP:   if (w_gap_end) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bytes_left   <= '0;
            r_seed         <= '0;
            r_total_bits   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_req_first    <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_flag_seen    <= 1'b0;
            r_tail_cnt     <= '0;
            r_gap_cnt      <= '0;
        end else begin
            r_done      <= 1'b0;
            r_req_first <= 1'b0;
            if (w_accept) begin
                r_seed         <= i_seed;
                r_total_bits   <= {3'b000, i_pdu_len, 3'b000};
                r_bytes_left   <= LW'(i_pdu_len);
                r_err_underrun <= 1'b0;
                r_err_timeout  <= 1'b0;
                if (i_pdu_len == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy      <= 1'b1;
                    r_req_first <= 1'b1;
                end
            end
            if (w_load_first || w_reload) r_bytes_left <= r_bytes_left - LW'(1);
            if (w_underrun) r_err_underrun <= 1'b1;
            // A flag fall on the final tail cycle still counts as success.
            if (w_tail_exp && !w_flag_fall) r_err_timeout <= 1'b1;
            if (r_state == ST_TAIL) begin
                r_tail_cnt <= r_tail_cnt + TW'(1);
                if (i_crc_flag) r_flag_seen <= 1'b1;
            end else begin
                r_tail_cnt  <= '0;
                r_flag_seen <= 1'b0;
            end
            if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
            else                   r_gap_cnt <= '0;
            if (w_gap_end) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    // The first request comes from the start handshake; later ones are
    // issued while bit 0 of a byte is on the wire, if bytes remain.
    assign o_byte_req     = r_req_first || (w_shift_en && w_need_byte && w_more);
    assign o_crc_uap_dci  = r_seed;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_total_bits   = r_total_bits;
    assign o_err_underrun = r_err_underrun;
    assign o_err_timeout  = r_err_timeout;

endmodule
